// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Three-port arbiter for the shared program/data memory; sequences
//            one access at a time and returns a one-cycle ack with read data.
//            Define MEM_ARB_RR_EN for round-robin, otherwise fixed priority 0>1>2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int WAIT = 1
) (
    input  logic            clk,
    input  logic            CLB,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    output logic [2:0]      gnt,
    output logic [2:0]      ack,
    output logic [DW-1:0]   rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAITRD = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] c_WAIT_LOAD = 2'(WAIT - 1);

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_win, w_win_nxt;
    logic            r_wr, w_wr_nxt;
    logic [1:0]      r_cnt, w_cnt_nxt;

    logic [2:0]      w_gnt_nxt, w_ack_nxt;
    logic [DW-1:0]   w_rdata_nxt;
    logic            w_mem_en_nxt, w_mem_we_nxt;
    logic [AW-1:0]   w_mem_addr_nxt;
    logic [DW-1:0]   w_mem_wdata_nxt;

    logic [1:0]      w_pick;
    logic            w_sel_we;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;

`ifdef MEM_ARB_RR_EN
    logic [1:0] r_last;

    // Search starts one past the last winner and wraps modulo 3.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        w_pick = 2'd0;
        found  = 1'b0;
        idx    = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        for (int k = 0; k < 3; k++) begin
            if (!found && req[idx]) begin
                w_pick = idx;
                found  = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            r_last <= 2'd2;
        end else if (r_state == RESP) begin
            r_last <= r_win;
        end
    end
`else
    always_comb begin
        if (req[0])      w_pick = 2'd0;
        else if (req[1]) w_pick = 2'd1;
        else             w_pick = 2'd2;
    end
`endif

    always_comb begin
        w_sel_we    = we[0];
        w_sel_addr  = addr[AW-1:0];
        w_sel_wdata = wdata[DW-1:0];
        for (int i = 1; i < 3; i++) begin
            if (w_pick == 2'(i)) begin
                w_sel_we    = we[i];
                w_sel_addr  = addr[i*AW +: AW];
                w_sel_wdata = wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_win_nxt       = r_win;
        w_wr_nxt        = r_wr;
        w_cnt_nxt       = r_cnt;
        w_gnt_nxt       = gnt;
        w_ack_nxt       = 3'b000;
        w_rdata_nxt     = rdata;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = mem_addr;
        w_mem_wdata_nxt = mem_wdata;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_win_nxt       = w_pick;
                    w_wr_nxt        = w_sel_we;
                    w_gnt_nxt       = 3'b001 << w_pick;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = w_sel_we;
                    w_mem_addr_nxt  = w_sel_addr;
                    w_mem_wdata_nxt = w_sel_wdata;
                    w_state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (r_wr) begin
                    w_ack_nxt   = 3'b001 << r_win;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt   = c_WAIT_LOAD;
                    w_state_nxt = WAITRD;
                end
            end
            WAITRD: begin
                // Zero count means the memory data is valid at this edge.
                if (r_cnt == 2'd0) begin
                    w_rdata_nxt = mem_rdata;
                    w_ack_nxt   = 3'b001 << r_win;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            RESP: begin
                w_gnt_nxt   = 3'b000;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            r_state   <= IDLE;
            r_win     <= 2'd0;
            r_wr      <= 1'b0;
            r_cnt     <= 2'd0;
            gnt       <= 3'b000;
            ack       <= 3'b000;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_win     <= w_win_nxt;
            r_wr      <= w_wr_nxt;
            r_cnt     <= w_cnt_nxt;
            gnt       <= w_gnt_nxt;
            ack       <= w_ack_nxt;
            rdata     <= w_rdata_nxt;
            mem_en    <= w_mem_en_nxt;
            mem_we    <= w_mem_we_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed bench for mem_arbiter (WAIT=1 main instance plus a WAIT=3
//            instance); acks are matched against a queue of expected results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        CLB;
    logic [2:0]  req, we, gnt, ack;
    logic [23:0] addr, wdata;
    logic [7:0]  rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;

    logic [2:0]  req3, we3, gnt3, ack3;
    logic [23:0] addr3, wdata3;
    logic [7:0]  rdata3, mem3_addr, mem3_wdata, mem3_rdata;
    logic        mem3_en, mem3_we;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(8), .DW(8), .WAIT(1)) dut (
        .clk(clk), .CLB(CLB), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.AW(8), .DW(8), .WAIT(3)) dut3 (
        .clk(clk), .CLB(CLB), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
        .gnt(gnt3), .ack(ack3), .rdata(rdata3), .mem_en(mem3_en), .mem_we(mem3_we),
        .mem_addr(mem3_addr), .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata)
    );

    // Memory model: unwritten locations read as addr ^ 8'hB5.
    logic [7:0]   mem [256];
    logic [255:0] written = '0;
    logic [7:0]   ra = 8'h00;
    logic [7:0]   ra3 = 8'h00;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end
            ra <= mem_addr;
        end
        if (mem3_en) ra3 <= mem3_addr;
    end
    assign mem_rdata  = written[ra] ? mem[ra] : (ra ^ 8'hB5);
    assign mem3_rdata = ra3 ^ 8'hB5;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0] port;
        logic       rd;
        logic [7:0] data;
    } exp_t;
    exp_t       sbq[$];
    exp_t       mon_e;
    logic [7:0] exp_mem [256];
    bit [255:0] exp_wr;

    function automatic logic [7:0] exp_rd(input logic [7:0] a);
        return exp_wr[a] ? exp_mem[a] : (a ^ 8'hB5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic prev_en = 1'b0;
    always @(negedge clk) begin
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
        check("mem_en_gap", 32'(prev_en & mem_en), 32'd0);
        prev_en <= mem_en;
        if (ack !== 3'b000) begin
            if (sbq.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("ack_port", 32'(ack), 32'(3'b001 << mon_e.port));
                if (mon_e.rd) check("rdata", 32'(rdata), 32'(mon_e.data));
            end
        end
    end

    // Issue one access on port p; lat = edges from grant to ack.
    task automatic access(input int p, input logic w, input logic [7:0] a,
                          input logic [7:0] d, output int lat);
        int n;
        addr[p*8 +: 8]  = a;
        wdata[p*8 +: 8] = d;
        we[p]           = w;
        req[p]          = 1'b1;
        sbq.push_back({2'(p), ~w, w ? 8'h00 : exp_rd(a)});
        if (w) begin
            exp_mem[a] = d;
            exp_wr[a]  = 1'b1;
        end
        n = 0;
        do begin tick; n++; end while (gnt[p] !== 1'b1 && n < 20);
        n = 0;
        while (ack[p] !== 1'b1 && n < 20) begin tick; n++; end
        req[p] = 1'b0;
        check("ack_seen", 32'(ack[p]), 32'd1);
        lat = n;
    endtask

    int   lat, n, c1, c2, g;
    logic ack_seen;
    int   exp_order[5];

    initial begin
        CLB = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_mem", 32'({mem_en, mem_we, mem_addr, mem_wdata, rdata}), 32'd0);
        CLB = 1'b1;
        tick;

        // Single read, port 0, addr 0x10 -> 0xA5
        sbq.push_back({2'd0, 1'b1, 8'hA5});
        addr[7:0] = 8'h10; we[0] = 1'b0; req[0] = 1'b1;
        tick;
        check("rd_gnt", 32'(gnt), 32'b001);
        check("rd_mem_en", 32'(mem_en), 32'd1);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        check("rd_mem_addr", 32'(mem_addr), 32'h10);
        tick;
        check("rd_en_drop", 32'(mem_en), 32'd0);
        check("rd_no_ack_yet", 32'(ack), 32'd0);
        tick;
        check("rd_ack", 32'(ack), 32'b001);
        check("rd_data", 32'(rdata), 32'hA5);
        req[0] = 1'b0;
        tick;
        check("rd_release", 32'({gnt, ack}), 32'd0);

        // Single write, port 1, 0x20 <= 0x3C
        sbq.push_back({2'd1, 1'b0, 8'h00});
        exp_mem[8'h20] = 8'h3C; exp_wr[8'h20] = 1'b1;
        addr[15:8] = 8'h20; wdata[15:8] = 8'h3C; we[1] = 1'b1; req[1] = 1'b1;
        tick;
        check("wr_gnt", 32'(gnt), 32'b010);
        check("wr_mem", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'({2'b11, 8'h20, 8'h3C}));
        check("wr_no_ack_yet", 32'(ack), 32'd0);
        tick;
        check("wr_ack", 32'(ack), 32'b010);
        check("wr_en_drop", 32'({mem_en, mem_we}), 32'd0);
        req[1] = 1'b0;
        tick;
        check("wr_release", 32'(gnt), 32'd0);

        access(0, 1'b0, 8'h20, 8'h00, lat);
        check("rdback_lat", 32'(lat), 32'd2);
        access(2, 1'b1, 8'h70, 8'h11, lat);
        c1 = cyc;
        check("wr_lat", 32'(lat), 32'd1);
        access(2, 1'b1, 8'h71, 8'h22, lat);
        c2 = cyc;
        check("b2b_wr_spacing", 32'(c2 - c1), 32'd3);
        access(1, 1'b0, 8'h71, 8'h00, lat);

        // Violation: req dropped and addr changed right after grant
        sbq.push_back({2'd1, 1'b1, 8'h86});
        addr[15:8] = 8'h33; we[1] = 1'b0; req[1] = 1'b1;
        n = 0;
        do begin tick; n++; end while (gnt[1] !== 1'b1 && n < 20);
        check("viol_gnt", 32'(gnt), 32'b010);
        check("viol_mem_addr", 32'(mem_addr), 32'h33);
        req[1] = 1'b0; addr[15:8] = 8'h44; we[1] = 1'b1;
        n = 0;
        while (ack[1] !== 1'b1 && n < 20) begin tick; n++; end
        check("viol_ack", 32'(ack), 32'b010);
        check("viol_mem_addr_held", 32'(mem_addr), 32'h33);
        we[1] = 1'b0;
        tick;

        // Reset during WAITRD: outputs clear at once, no ack ever follows
        addr[7:0] = 8'h10; we[0] = 1'b0; req[0] = 1'b1;
        n = 0;
        do begin tick; n++; end while (gnt[0] !== 1'b1 && n < 20);
        tick;
        CLB = 1'b0;
        #1;
        check("mid_rst_clear", 32'({gnt, ack, mem_en}), 32'd0);
        req[0] = 1'b0;
        tick;
        CLB = 1'b1;
        ack_seen = 1'b0;
        repeat (6) begin tick; ack_seen = ack_seen | (|ack); end
        check("mid_rst_no_ack", 32'(ack_seen), 32'd0);

        // Contention: all three ports hold req
`ifdef MEM_ARB_RR_EN
        exp_order = '{0, 1, 2, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        we = 3'b000;
        addr = {8'h03, 8'h02, 8'h01};
        for (int k = 0; k < 5; k++)
            sbq.push_back({2'(exp_order[k]), 1'b1, exp_rd(addr[exp_order[k]*8 +: 8])});
        req = 3'b111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (gnt === 3'b000 && n < 20) begin tick; n++; end
            check("cont_gnt", 32'(gnt), 32'(3'b001 << exp_order[k]));
            if (k == 4) req = 3'b000;
            n = 0;
            while (gnt !== 3'b000 && n < 20) begin tick; n++; end
        end
        tick;

        // WAIT=3 instance: port 2 read latency and back-to-back spacing
        addr3[23:16] = 8'h55; req3 = 3'b100;
        n = 0;
        do begin tick; n++; end while (gnt3[2] !== 1'b1 && n < 20);
        g = cyc;
        n = 0;
        while (ack3[2] !== 1'b1 && n < 20) begin tick; n++; end
        c1 = cyc;
        check("w3_lat", 32'(c1 - g), 32'd4);
        check("w3_rdata", 32'(rdata3), 32'hE0);
        tick;
        n = 0;
        while (ack3[2] !== 1'b1 && n < 20) begin tick; n++; end
        c2 = cyc;
        check("w3_b2b_spacing", 32'(c2 - c1), 32'd6);
        req3 = 3'b000;
        repeat (3) tick;
        check("w3_idle", 32'({gnt3, ack3}), 32'd0);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
